sbox_sweep_checker: RTL
=======================

# sbox_sweep_checker

Sequential property checker that sits directly downstream of a 6-bit combinational S-box stage (for example `SMS32_2_38_pn_18_2`). On command it drives every input value 0..63 into the S-box, one per clock, and consumes the returned outputs. It reports bijectivity, the first colliding input, the number of fixed points and the per-bit output weights. The S-box is instantiated beside this block: `sbox_x` feeds the S-box input and the S-box output returns on `sbox_y`.

## Interface
- `WIDTH`, 6: S-box word width; `DEPTH` = 2**`WIDTH` (64) is derived, not overridable.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `start`  in  1  request a sweep; honoured only in IDLE or DONE.
- `sbox_x`  out  WIDTH  registered input driven to the S-box.
- `sbox_y`  in  WIDTH  combinational S-box response to `sbox_x`, sampled the same cycle.
- `busy`  out  1  high throughout SWEEP.
- `done`  out  1  one-cycle pulse on entry to DONE.
- `is_perm`  out  1  1 if no output value repeated.
- `coll_valid`  out  1  at least one collision seen.
- `coll_x`  out  WIDTH  first input whose output had already occurred.
- `fixed_cnt`  out  WIDTH+1  count of x with S(x)==x (0..64).
- `weight`  out  6*(WIDTH+1)  packed per-bit ones count; bits [7k+6:7k] hold the weight of output bit k.

## Operation
- States: IDLE, SWEEP, DONE.
- IDLE or DONE with `start`=1 goes to SWEEP. On that edge:
  - idx=0, `sbox_x`=0;
  - 64-bit `seen` bitmap, `fixed_cnt`, `weight`, `coll_valid` and `coll_x` cleared;
  - `is_perm` set to 1.
- SWEEP, each cycle, with y=`sbox_y` and x=`sbox_x`:
  - if `seen[y]`: `is_perm`<=0, and if `coll_valid`==0 then `coll_valid`<=1 and `coll_x`<=x;
  - `seen[y]`<=1;
  - if y==x, `fixed_cnt` increments;
  - each `weight` field k increments by y[k];
  - if x==63, go to DONE; else `sbox_x`<=x+1.
- DONE holds all results stable until the next accepted `start` or `rst`.
- `start` during SWEEP is ignored; the sweep is not restarted.
- `done`=1 only on the first DONE cycle.
- Width rules:
  - counters are WIDTH+1 bits, so 64 is representable and no wrap is possible;
  - `sbox_x` never wraps, because the x==63 check exits SWEEP first.
- `rst` at any time, including mid-sweep, forces IDLE and the reset values below; partial results are discarded.

## Timing
- Reset values: `sbox_x`=0, `busy`=0, `done`=0, `is_perm`=0, `coll_valid`=0, `coll_x`=0, `fixed_cnt`=0, `weight`=0, `seen`=0.
- `start` sampled at edge E0. `busy`=1 from E0 through the edge where x=63 is consumed, which is E64.
- `done` is high for the cycle after E64; the full sweep takes 64 cycles.
- Results are valid and stable from the `done` cycle onward.
- `start` in the `done` cycle is accepted and a new sweep begins at once; results clear on that edge.
- The S-box path (`sbox_x` to `sbox_y`) must close within one clock period. No pipeline register is allowed inside the loop.

## Structure
- Shared package `sbox_pkg`:
  - `WIDTH`, `DEPTH`;
  - state enum `sweep_state_t` {IDLE, SWEEP, DONE};
  - a packing function for the `weight` bus.
- One sub-module is natural: `bit_weight_acc`, instantiated 6 times. Each instance is a 7-bit counter with synchronous clear and increment-enable.
- `seen` is a flat 64-bit register, not RAM, so the read and set of `seen[y]` happen in the same cycle.

## Test plan
- **Identity S-box** (`sbox_y`=`sbox_x`): `is_perm`=1, `coll_valid`=0, `fixed_cnt`=64, every weight=32, `done` one cycle after E64.
- **Reference S-box** (`SMS32_2_38_pn_18_2` attached): `is_perm` and `fixed_cnt` match a software golden model over all 64 inputs.
- **Constant output 5**: `is_perm`=0, `coll_x`=1, `coll_valid`=1, weights = {0,0,0,64,0,64} in order bit5..bit0, `fixed_cnt`=1.
- **Collision at the end**: y=x except S(63)=0 → `is_perm`=0, `coll_x`=63, `fixed_cnt`=63.
- **`start` re-pulsed during SWEEP**: completion cycle and results are unchanged.
- **`rst` at x=30**: all outputs return to reset values the next cycle. A later `start` then produces a full, correct 64-cycle sweep.

Source files
------------

// File: rtl/sbox_sweep_checker_pkg.sv
// sbox_pkg: shared definitions for the S-box sweep checker.
//   WIDTH / DEPTH : S-box word width and number of inputs (2**WIDTH)
//   CW            : width of all counters (WIDTH+1, so DEPTH fits exactly)
//   sweep_state_t : checker FSM states
//   pack_weight   : flattens the per-bit weight counters onto the output bus
package sbox_pkg;

  localparam int WIDTH = 6;
  localparam int DEPTH = 2 ** WIDTH;
  localparam int CW    = WIDTH + 1;

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} sweep_state_t;

  // Field k of the flat bus (bits [CW*k +: CW]) is the weight of output bit k.
  function automatic logic [WIDTH*CW-1:0] pack_weight(input logic [WIDTH-1:0][CW-1:0] w);
    logic [WIDTH*CW-1:0] flat;
    flat = '0;
    for (int k = 0; k < WIDTH; k++) flat[CW*k +: CW] = w[k];
    return flat;
  endfunction

endpackage

// File: rtl/sbox_sweep_checker_bit_weight_acc.sv
// bit_weight_acc: ones counter for a single S-box output bit.
//   clk, rst : clock, synchronous active-high reset
//   clr      : synchronous clear (start of a new sweep)
//   inc      : add one this cycle
//   cnt      : current count
module bit_weight_acc #(
  parameter int CW = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (inc)   cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/sbox_sweep_checker.sv
// sbox_sweep_checker: drives every input 0..DEPTH-1 into an adjacent
// combinational S-box, one per clock, and reports bijectivity, the first
// colliding input, the fixed-point count and per-bit output weights.
//   clk, rst   : clock, synchronous active-high reset
//   start      : begin a sweep (accepted in IDLE or DONE)
//   sbox_x     : registered S-box input
//   sbox_y     : S-box response to sbox_x, consumed the same cycle
//   busy       : high while sweeping
//   done       : one-cycle pulse on entry to DONE
//   is_perm    : no output value repeated
//   coll_valid : a collision was seen; coll_x is the first colliding input
//   fixed_cnt  : number of x with S(x)==x
//   weight     : packed per-output-bit ones counts
module sbox_sweep_checker
  import sbox_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic [WIDTH-1:0]    sbox_x,
  input  logic [WIDTH-1:0]    sbox_y,
  output logic                busy,
  output logic                done,
  output logic                is_perm,
  output logic                coll_valid,
  output logic [WIDTH-1:0]    coll_x,
  output logic [CW-1:0]       fixed_cnt,
  output logic [WIDTH*CW-1:0] weight
);

  sweep_state_t             state;
  logic [DEPTH-1:0]         seen;
  logic [WIDTH-1:0][CW-1:0] wcnt;
  logic                     accept;
  logic                     sweeping;
  logic                     last_x;

  assign accept   = start && (state != SWEEP);
  assign sweeping = (state == SWEEP);
  assign last_x   = (sbox_x == WIDTH'(DEPTH - 1));

  for (genvar k = 0; k < WIDTH; k++) begin : g_wacc
    bit_weight_acc #(.CW(CW)) u_wacc (
      .clk (clk),
      .rst (rst),
      .clr (accept),
      .inc (sweeping & sbox_y[k]),
      .cnt (wcnt[k])
    );
  end

  assign weight = pack_weight(wcnt);

  // seen is a flat register so the lookup and the set of seen[y] resolve
  // in the same cycle as the S-box response; the loop has no pipeline stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sbox_x     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      is_perm    <= 1'b0;
      coll_valid <= 1'b0;
      coll_x     <= '0;
      fixed_cnt  <= '0;
      seen       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= SWEEP;
            busy       <= 1'b1;
            sbox_x     <= '0;
            seen       <= '0;
            fixed_cnt  <= '0;
            coll_valid <= 1'b0;
            coll_x     <= '0;
            is_perm    <= 1'b1;
          end
        end
        SWEEP: begin
          if (seen[sbox_y]) begin
            is_perm <= 1'b0;
            if (!coll_valid) begin
              coll_valid <= 1'b1;
              coll_x     <= sbox_x;
            end
          end
          seen[sbox_y] <= 1'b1;
          if (sbox_y == sbox_x) fixed_cnt <= fixed_cnt + 1'b1;
          // Exit on the last input so sbox_x never wraps.
          if (last_x) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            sbox_x <= sbox_x + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
